int_vector_ctrl: RTL and testbench

Vectored interrupt controller upstream of the single-cycle MIPS core. It edge-detects completion strobes from four peripherals and latches them as pending. It arbitrates among enabled pending sources by fixed priority and presents one request at a time to the core's interrupt encoder, together with a stable handler vector address. It tracks the handshake through acknowledge and handler return.

---
 rtl/int_vector_ctrl_pkg.sv | 22 ++
 rtl/int_vector_ctrl_if.sv | 21 ++
 rtl/int_vector_ctrl_prio_enc4.sv | 18 +
 rtl/int_vector_ctrl.sv | 90 +++++++++
 tb/tb_int_vector_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/int_vector_ctrl_pkg.sv
// Shared types and constants for the vectored interrupt controller.
// State encoding, default vector layout and the handler-address helper.
package int_vec_pkg;

  localparam int          NSRC           = 4;
  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0020;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } state_t;

  // 32-bit unsigned wrap-around; the source index is zero-extended.
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [1:0]  idx);
    return base + ({30'b0, idx} * stride);
  endfunction

endpackage

// File: rtl/int_vector_ctrl_if.sv
// Request/acknowledge handshake between the interrupt controller and the core.
// The controller drives the request side (master); the core answers (slave).
interface int_vector_ctrl_if;

  logic        interrupt;
  logic [31:0] int_addr;
  logic [1:0]  int_id;
  logic        int_ack;
  logic        int_done;

  modport master (
    output interrupt, int_addr, int_id,
    input  int_ack, int_done
  );

  modport slave (
    input  interrupt, int_addr, int_id,
    output int_ack, int_done
  );

endinterface

// File: rtl/int_vector_ctrl_prio_enc4.sv
// Fixed-priority encoder over four candidates; the lowest set index wins.
module prio_enc4 (
  input  logic [3:0] cand,
  output logic       any,
  output logic [1:0] idx
);

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    any = |cand;
    idx = 2'd0;
    if (cand[0])      idx = 2'd0;
    else if (cand[1]) idx = 2'd1;
    else if (cand[2]) idx = 2'd2;
    else if (cand[3]) idx = 2'd3;
  end

endmodule

// File: rtl/int_vector_ctrl.sv
// Vectored interrupt controller: edge-detects peripheral completions, arbitrates
// enabled pending sources by fixed priority and tracks the core handshake.
module int_vector_ctrl #(
  parameter int          NSRC       = int_vec_pkg::NSRC,
  parameter logic [31:0] VEC_BASE   = int_vec_pkg::VEC_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE = int_vec_pkg::VEC_STRIDE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NSRC-1:0]    done,
  input  logic [NSRC-1:0]    en_mask,
  int_vector_ctrl_if.master  core,
  output logic [NSRC-1:0]    pending,
  output logic               busy
);

  import int_vec_pkg::*;

  state_t          state, state_d;
  logic [NSRC-1:0] done_q;
  logic            armed;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pending_d;
  logic            win_any;
  logic [1:0]      win_idx;
  logic            load_req;
  logic            ack_take;

  prio_enc4 u_prio (
    .cand (pending & en_mask),
    .any  (win_any),
    .idx  (win_idx)
  );

  // armed blocks the first edge after reset so a level already high is not an event.
  assign rise     = armed ? (done & ~done_q) : '0;
  assign ack_take = (state == REQ) && core.int_ack;
  assign busy     = (state != IDLE);

  always_comb begin
    pending_d = pending;
    if (ack_take) pending_d[core.int_id] = 1'b0;
    pending_d = pending_d | rise;
  end

  always_comb begin
    state_d  = state;
    load_req = 1'b0;
    unique case (state)
      IDLE: if (win_any) begin
        state_d  = REQ;
        load_req = 1'b1;
      end
      REQ:     if (core.int_ack)  state_d = SERVICE;
      SERVICE: if (core.int_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      done_q  <= '0;
      armed   <= 1'b0;
      pending <= '0;
    end else begin
      state   <= state_d;
      done_q  <= done;
      armed   <= 1'b1;
      pending <= pending_d;
    end
  end

  // Vector registers load only on IDLE->REQ and stay frozen through SERVICE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core.interrupt <= 1'b0;
      core.int_id    <= 2'd0;
      core.int_addr  <= 32'h0;
    end else if (load_req) begin
      core.interrupt <= 1'b1;
      core.int_id    <= win_idx;
      core.int_addr  <= vec_addr(VEC_BASE, VEC_STRIDE, win_idx);
    end else if (ack_take) begin
      core.interrupt <= 1'b0;
    end
  end

endmodule

// File: tb/tb_int_vector_ctrl.sv
// Directed self-checking bench for int_vector_ctrl: handshake, priority, masking,
// coalescing, stray handshakes and asynchronous reset.
module tb_int_vector_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] done;
  logic [3:0] en_mask;
  logic [3:0] pending;
  logic       busy;

  int passed = 0;
  int total  = 0;

  int_vector_ctrl_if bus ();

  int_vector_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .done    (done),
    .en_mask (en_mask),
    .core    (bus),
    .pending (pending),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_vec(input string tag, input logic irq, input logic [1:0] id,
                           input logic [31:0] addr);
    check({tag, "_irq"},  32'(bus.interrupt), 32'(irq));
    check({tag, "_id"},   32'(bus.int_id),    32'(id));
    check({tag, "_addr"}, bus.int_addr,       addr);
  endtask

  initial begin
    reset        = 1'b1;
    done         = 4'h0;
    en_mask      = 4'hF;
    bus.int_ack  = 1'b0;
    bus.int_done = 1'b0;
    step();
    step();
    check_vec("rst", 1'b0, 2'd0, 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    reset = 1'b0;
    step();

    // Single source 2
    done = 4'b0100;
    step();
    done = 4'b0000;
    check("s1_pending", 32'(pending), 32'h4);
    check("s1_irq_early", 32'(bus.interrupt), 32'h0);
    step();
    check_vec("s1_req", 1'b1, 2'd2, 32'h140);
    check("s1_busy", 32'(busy), 32'h1);
    bus.int_ack = 1'b1;
    step();
    bus.int_ack = 1'b0;
    check("s1_ack_irq", 32'(bus.interrupt), 32'h0);
    check("s1_ack_pending", 32'(pending), 32'h0);
    check("s1_svc_busy", 32'(busy), 32'h1);
    check("s1_svc_addr", bus.int_addr, 32'h140);
    bus.int_done = 1'b1;
    step();
    bus.int_done = 1'b0;
    check("s1_ret_busy", 32'(busy), 32'h0);

    // Priority: sources 3 and 1 together
    done = 4'b1010;
    step();
    done = 4'b0000;
    check("pr_pending", 32'(pending), 32'hA);
    step();
    check_vec("pr_first", 1'b1, 2'd1, 32'h120);
    bus.int_ack = 1'b1;
    step();
    bus.int_ack = 1'b0;
    check("pr_pending2", 32'(pending), 32'h8);
    bus.int_done = 1'b1;
    step();
    bus.int_done = 1'b0;
    check("pr_idle", 32'(busy), 32'h0);
    step();
    check_vec("pr_second", 1'b1, 2'd3, 32'h160);
    bus.int_ack = 1'b1;
    step();
    bus.int_ack  = 1'b0;
    bus.int_done = 1'b1;
    step();
    bus.int_done = 1'b0;

    // Masked source 0
    en_mask = 4'b1110;
    done    = 4'b0001;
    step();
    done = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      check("mk_irq_low", 32'(bus.interrupt), 32'h0);
      step();
    end
    check("mk_pending", 32'(pending), 32'h1);
    check("mk_busy", 32'(busy), 32'h0);
    en_mask = 4'hF;
    step();
    check_vec("mk_unmask", 1'b1, 2'd0, 32'h100);
    bus.int_ack = 1'b1;
    step();
    bus.int_ack  = 1'b0;
    bus.int_done = 1'b1;
    step();
    bus.int_done = 1'b0;

    // Frozen vector and coalescing
    done = 4'b0100;
    step();
    done = 4'b0000;
    step();
    check_vec("fz_req", 1'b1, 2'd2, 32'h140);
    done = 4'b0001;
    step();
    done = 4'b0000;
    check_vec("fz_frozen", 1'b1, 2'd2, 32'h140);
    check("fz_pending", 32'(pending), 32'h5);
    bus.int_ack = 1'b1;
    step();
    bus.int_ack = 1'b0;
    check("fz_ack_pending", 32'(pending), 32'h1);
    done = 4'b0100;
    step();
    done = 4'b0000;
    step();
    done = 4'b0100;
    step();
    done = 4'b0000;
    step();
    check("co_pending", 32'(pending), 32'h5);
    check("co_busy", 32'(busy), 32'h1);
    check_vec("co_svc_hold", 1'b0, 2'd2, 32'h140);
    bus.int_done = 1'b1;
    step();
    bus.int_done = 1'b0;
    step();
    check_vec("co_src0", 1'b1, 2'd0, 32'h100);
    bus.int_ack = 1'b1;
    step();
    bus.int_ack = 1'b0;
    check("co_pending_after0", 32'(pending), 32'h4);
    bus.int_done = 1'b1;
    step();
    bus.int_done = 1'b0;
    step();
    check_vec("co_src2", 1'b1, 2'd2, 32'h140);
    bus.int_ack = 1'b1;
    step();
    bus.int_ack = 1'b0;
    check("co_pending_empty", 32'(pending), 32'h0);
    bus.int_done = 1'b1;
    step();
    bus.int_done = 1'b0;
    step();
    step();
    step();
    check("co_no_extra_irq", 32'(bus.interrupt), 32'h0);
    check("co_no_extra_busy", 32'(busy), 32'h0);

    // Stray and simultaneous handshakes
    bus.int_ack = 1'b1;
    step();
    bus.int_ack = 1'b0;
    check("st_ack_idle_busy", 32'(busy), 32'h0);
    check("st_ack_idle_irq", 32'(bus.interrupt), 32'h0);
    done = 4'b0010;
    step();
    done = 4'b0000;
    step();
    check_vec("st_req1", 1'b1, 2'd1, 32'h120);
    bus.int_done = 1'b1;
    step();
    bus.int_done = 1'b0;
    check("st_done_req_irq", 32'(bus.interrupt), 32'h1);
    check("st_done_req_busy", 32'(busy), 32'h1);
    bus.int_ack  = 1'b1;
    bus.int_done = 1'b1;
    done         = 4'b0010;
    step();
    bus.int_ack  = 1'b0;
    bus.int_done = 1'b0;
    done         = 4'b0000;
    check("st_both_irq", 32'(bus.interrupt), 32'h0);
    check("st_both_busy", 32'(busy), 32'h1);
    check("st_set_wins", 32'(pending), 32'h2);
    step();
    check("st_still_svc", 32'(busy), 32'h1);
    bus.int_done = 1'b1;
    step();
    bus.int_done = 1'b0;
    step();
    check_vec("st_rereq1", 1'b1, 2'd1, 32'h120);
    bus.int_ack = 1'b1;
    step();
    bus.int_ack  = 1'b0;
    bus.int_done = 1'b1;
    step();
    bus.int_done = 1'b0;

    // Asynchronous reset mid-SERVICE
    done = 4'b1000;
    step();
    done = 4'b0000;
    step();
    check_vec("rs_req", 1'b1, 2'd3, 32'h160);
    bus.int_ack = 1'b1;
    step();
    bus.int_ack = 1'b0;
    done = 4'b0001;
    step();
    check("rs_svc_pending", 32'(pending), 32'h1);
    check("rs_svc_busy", 32'(busy), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_vec("rs_async", 1'b0, 2'd0, 32'h0);
    check("rs_async_pending", 32'(pending), 32'h0);
    check("rs_async_busy", 32'(busy), 32'h0);
    done = 4'b1111;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rs_no_event_irq", 32'(bus.interrupt), 32'h0);
      check("rs_no_event_pending", 32'(pending), 32'h0);
    end
    check("rs_no_event_busy", 32'(busy), 32'h0);
    done = 4'b0000;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
